cra_sbr_stack: RTL and testbench

CRA_SBR_STACK -- requirements
Module: cra_sbr_stack

---
 rtl/cra_pkg.sv | 6 +
 rtl/cra_stk_ram.sv | 21 ++
 rtl/cra_sbr_stack.sv | 62 ++++++
 tb/tb_cra_sbr_stack.sv | 111 +++++++++++
 4 files changed

// File: rtl/cra_pkg.sv
// cra_pkg: shared CRAM address width, address type and default return-stack depth.
package cra_pkg;
  localparam int ADR_W = 11;
  localparam int DEPTH = 16;
  typedef logic [ADR_W-1:0] cra_adr_t;
endpackage

// File: rtl/cra_stk_ram.sv
// cra_stk_ram: return-address storage, one synchronous write port and two asynchronous read ports.
module cra_stk_ram #(
  parameter int DEPTH = cra_pkg::DEPTH,
  parameter int ADR_W = cra_pkg::ADR_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [ADR_W-1:0] wd,
  input  logic [AW-1:0]    top_a,
  output logic [ADR_W-1:0] top_d,
  input  logic [AW-1:0]    diag_a,
  output logic [ADR_W-1:0] diag_d
);
  logic [ADR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign top_d  = mem[top_a];
  assign diag_d = mem[diag_a];
endmodule

// File: rtl/cra_sbr_stack.sv
// cra_sbr_stack: microcode subroutine return-address stack with sticky overflow/underflow
// flags and a diagnostic read/clear path.
module cra_sbr_stack #(
  parameter int DEPTH = cra_pkg::DEPTH,
  parameter int ADR_W = cra_pkg::ADR_W
) (
  input  logic                     clk_cra_h,
  input  logic                     mr_reset_01_h,
  input  logic                     cra_call_h,
  input  logic                     cra_ret_h,
  input  logic [ADR_W-1:0]         cra_adr_h,
  output logic [ADR_W-1:0]         cra_sbr_adr_h,
  output logic                     cra_stk_empty_h,
  output logic                     cra_stk_full_h,
  output logic                     cra_stk_ovf_h,
  output logic                     cra_stk_unf_h,
  input  logic                     diag_load_func_stk_clr_l,
  input  logic                     diag_read_func_14x_l,
  input  logic [$clog2(DEPTH)-1:0] diag_sel_h,
  output logic [ADR_W+1:0]         ebus_d_e_h
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  logic [SW-1:0] sp, sp_nx;
  logic [AW-1:0] top_idx, wa;
  logic [ADR_W-1:0] top_rd, diag_rd;
  logic ovf, unf, empty, full, clr, we;
  assign clr     = ~diag_load_func_stk_clr_l;
  assign empty   = sp == '0;
  assign full    = sp == SW'(DEPTH);
  assign top_idx = AW'(sp - 1'b1);
  // call+ret on a non-empty stack rewrites the top entry in place; reset or clear drop the write
  always_comb begin
    we    = cra_call_h & (cra_ret_h | ~full) & ~clr & ~mr_reset_01_h;
    wa    = (cra_ret_h & ~empty) ? top_idx : sp[AW-1:0];
    sp_nx = clr ? '0 :
            (cra_call_h & ~cra_ret_h & ~full)  ? sp + 1'b1 :
            (cra_ret_h  & ~cra_call_h & ~empty) ? sp - 1'b1 :
            (cra_call_h & cra_ret_h & empty)    ? SW'(1) : sp;
  end
  always_ff @(posedge clk_cra_h or posedge mr_reset_01_h)
    if (mr_reset_01_h) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      sp  <= sp_nx;
      ovf <= ~clr & (ovf | (cra_call_h & ~cra_ret_h & full));
      unf <= ~clr & (unf | (cra_ret_h & empty));
    end
  cra_stk_ram #(.DEPTH(DEPTH), .ADR_W(ADR_W), .AW(AW)) u_ram (
    .clk(clk_cra_h), .we(we), .wa(wa), .wd(cra_adr_h),
    .top_a(top_idx), .top_d(top_rd),
    .diag_a(diag_sel_h), .diag_d(diag_rd)
  );
  assign cra_sbr_adr_h   = empty ? '0 : top_rd;
  assign cra_stk_empty_h = empty;
  assign cra_stk_full_h  = full;
  assign cra_stk_ovf_h   = ovf;
  assign cra_stk_unf_h   = unf;
  assign ebus_d_e_h      = diag_read_func_14x_l ? '0 : {ovf, unf, diag_rd};
endmodule

// File: tb/tb_cra_sbr_stack.sv
// tb_cra_sbr_stack: directed stimulus feeding an expectation queue; a monitor drains and
// compares it on each falling edge and just after any reset assertion.
module tb_cra_sbr_stack;
  typedef struct {
    string       name;
    int          kind;
    logic [12:0] exp;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, call = 1'b0, ret = 1'b0, clr_l = 1'b1, rd_l = 1'b1;
  cra_pkg::cra_adr_t adr = '0, sbr;
  logic [3:0] sel = '0;
  logic empty, full, ovf, unf;
  logic [12:0] ebus;
  exp_t q[$];
  int total = 0, passed = 0;

  cra_sbr_stack dut (
    .clk_cra_h(clk), .mr_reset_01_h(rst), .cra_call_h(call), .cra_ret_h(ret),
    .cra_adr_h(adr), .cra_sbr_adr_h(sbr), .cra_stk_empty_h(empty), .cra_stk_full_h(full),
    .cra_stk_ovf_h(ovf), .cra_stk_unf_h(unf), .diag_load_func_stk_clr_l(clr_l),
    .diag_read_func_14x_l(rd_l), .diag_sel_h(sel), .ebus_d_e_h(ebus)
  );

  always #5 clk = ~clk;

  task automatic expect_v(input string name, input int kind, input logic [12:0] v);
    q.push_back('{name, kind, v});
  endtask

  task automatic outs(input string tag, input logic [10:0] s, input logic e, f, o, u);
    expect_v({tag, ".sbr"}, 0, {2'b00, s});
    expect_v({tag, ".empty"}, 1, {12'd0, e});
    expect_v({tag, ".full"}, 2, {12'd0, f});
    expect_v({tag, ".ovf"}, 3, {12'd0, o});
    expect_v({tag, ".unf"}, 4, {12'd0, u});
  endtask

  task automatic step(input logic c, r, input logic [10:0] a, input logic cl = 1'b1);
    call = c; ret = r; adr = a; clr_l = cl;
    @(posedge clk);
    #1;
    call = 1'b0; ret = 1'b0; clr_l = 1'b1;
  endtask

  initial forever begin
    @(negedge clk or posedge rst);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      logic [12:0] got;
      e = q.pop_front();
      got = e.kind == 0 ? {2'b00, sbr} : e.kind == 1 ? {12'd0, empty} :
            e.kind == 2 ? {12'd0, full} : e.kind == 3 ? {12'd0, ovf} :
            e.kind == 4 ? {12'd0, unf} : ebus;
      total++;
      if (got === e.exp) passed++;
      else $display("FAIL %s: got %0o expected %0o", e.name, got, e.exp);
    end
  end

  initial begin
    #1 rst = 1'b1;
    outs("reset", 11'o0, 1, 0, 0, 0);
    expect_v("reset.ebus", 5, 13'd0);
    @(negedge clk); #2 rst = 1'b0;
    step(1, 0, 11'o1234);
    step(1, 0, 11'o0777);
    step(1, 0, 11'o2001);
    outs("push3", 11'o2001, 0, 0, 0, 0);
    step(0, 1, 0); outs("ret1", 11'o0777, 0, 0, 0, 0);
    step(0, 1, 0); outs("ret2", 11'o1234, 0, 0, 0, 0);
    step(0, 1, 0); outs("ret3", 11'o0, 1, 0, 0, 0);
    step(0, 1, 0); outs("ret_unf", 11'o0, 1, 0, 0, 1);
    step(0, 0, 0, 0); outs("clr1", 11'o0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 11'(i));
    outs("fill16", 11'd15, 0, 1, 0, 0);
    step(1, 0, 11'o3777); outs("push_ovf", 11'd15, 0, 1, 1, 0);
    rd_l = 1'b0; sel = 4'd15;
    expect_v("diag15", 5, {1'b1, 1'b0, 11'd15});
    @(negedge clk); #2 rd_l = 1'b1;
    expect_v("diag_idle", 5, 13'd0);
    step(0, 0, 0, 0); outs("clr2", 11'o0, 1, 0, 0, 0);
    step(1, 0, 11'o50);
    step(1, 0, 11'o100); outs("sp2", 11'o100, 0, 0, 0, 0);
    step(1, 1, 11'o200); outs("replace", 11'o200, 0, 0, 0, 0);
    step(0, 1, 0); outs("after_replace", 11'o50, 0, 0, 0, 0);
    step(1, 0, 11'o100);
    step(1, 1, 11'o333, 0); outs("clr_over", 11'o0, 1, 0, 0, 0);
    rd_l = 1'b0; sel = 4'd0;
    expect_v("diag0_stale", 5, {2'b00, 11'o50});
    @(negedge clk); #2 sel = 4'd1;
    expect_v("diag1_stale", 5, {2'b00, 11'o100});
    @(negedge clk); #2 rd_l = 1'b1;
    step(1, 1, 11'o7); outs("callret_empty", 11'o7, 0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 11'(8 + i));
    outs("sp5", 11'o14, 0, 0, 0, 0);
    @(negedge clk); #2 rst = 1'b1;
    outs("async_rst", 11'o0, 1, 0, 0, 0);
    #4 rst = 1'b0;
    step(1, 0, 11'o21); outs("post_rst", 11'o21, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
